// File: rtl/pll_lock_reset_ctrl.sv
// PLL reset / lock supervisor on the free-running board clock.
// Holds the PLL in reset, qualifies lock, then releases the VGA-domain system reset.
module pll_lock_reset_ctrl #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       locked,
    input  logic       force_reset,
    input  logic       clear_status,
    output logic       pll_rst,
    output logic       sys_resetN,
    output logic       lock_ok,
    output logic       lock_lost,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                            PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ?
                            MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d, retry_inc;
    logic            lost_q, lost_d;
    logic            fail_q, fail_d;
    logic            set_lost, set_fail;
    logic            locked_meta, locked_sync;

    // locked comes from the PLL's own clock domain
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            locked_meta <= locked;
            locked_sync <= locked_meta;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_PLL_RESET;
            cnt_q   <= '0;
            retry_q <= '0;
            lost_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            lost_q  <= lost_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        set_lost  = 1'b0;
        set_fail  = 1'b0;
        retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

        if (force_reset) begin
            state_d = S_PLL_RESET;
            if (state_q == S_FAIL) begin
                retry_d = '0;
            end
        end else begin
            unique case (state_q)
                S_PLL_RESET: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (locked_sync) begin
                        state_d = S_STABILIZE;
                    end else if (cnt_q == TO_LAST) begin
                        retry_d = retry_inc;
                        if (retry_inc >= RETRY_LIMIT) begin
                            state_d  = S_FAIL;
                            set_fail = 1'b1;
                        end else begin
                            state_d = S_PLL_RESET;
                        end
                    end
                end
                S_STABILIZE: begin
                    cnt_d = cnt_q + CNT_ONE;
                    // a lock glitch restarts qualification, not a timeout
                    if (!locked_sync) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    if (!locked_sync) begin
                        state_d  = S_PLL_RESET;
                        set_lost = 1'b1;
                    end
                end
                S_FAIL: begin
                    if (clear_status) begin
                        state_d = S_PLL_RESET;
                        retry_d = '0;
                    end
                end
                default: begin
                    state_d = S_PLL_RESET;
                end
            endcase
        end

        if (force_reset || (state_d != state_q)) begin
            cnt_d = '0;
        end
    end

    assign lost_d = set_lost | (lost_q & ~clear_status);
    assign fail_d = set_fail | (fail_q & ~clear_status);

    assign pll_rst    = (state_q == S_PLL_RESET) || (state_q == S_FAIL);
    assign sys_resetN = (state_q == S_RUN);
    assign lock_ok    = (state_q == S_RUN);
    assign lock_lost  = lost_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Bench for pll_lock_reset_ctrl: directed scenarios then random traffic,
// all cycles compared against a phase/countdown reference model.
module tb_pll_lock_reset_ctrl;

    localparam int P_RST = 4;
    localparam int P_TO  = 32;
    localparam int P_STB = 8;
    localparam int P_MAX = 2;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       locked = 1'b0;
    logic       force_reset = 1'b0;
    logic       clear_status = 1'b0;
    logic       pll_rst, sys_resetN, lock_ok, lock_lost, fail;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 rst, 1 wait, 2 stable, 3 run, 4 fail
    int m_ph, m_left, m_retry;
    bit m_lost, m_fail, m_s1, m_s2;

    pll_lock_reset_ctrl #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .LOCK_STABLE_CYCLES(P_STB),
        .MAX_RETRIES(P_MAX)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .locked(locked),
        .force_reset(force_reset),
        .clear_status(clear_status),
        .pll_rst(pll_rst),
        .sys_resetN(sys_resetN),
        .lock_ok(lock_ok),
        .lock_lost(lock_lost),
        .fail(fail),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_enter(input int p);
        m_ph = p;
        case (p)
            0: m_left = P_RST;
            1: m_left = P_TO;
            2: m_left = P_STB;
            default: m_left = 0;
        endcase
    endfunction

    function automatic void m_reset();
        m_enter(0);
        m_retry = 0;
        m_lost = 0;
        m_fail = 0;
        m_s1 = 0;
        m_s2 = 0;
    endfunction

    function automatic void m_step();
        bit ls;
        bit sl;
        bit sf;
        ls = m_s2;
        sl = 0;
        sf = 0;
        m_s2 = m_s1;
        m_s1 = locked;
        if (force_reset) begin
            if (m_ph == 4) m_retry = 0;
            m_enter(0);
        end else begin
            case (m_ph)
                0: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_enter(1);
                end
                1: begin
                    if (ls) m_enter(2);
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                            if (m_retry >= P_MAX) begin
                                sf = 1;
                                m_enter(4);
                            end else m_enter(0);
                        end
                    end
                end
                2: begin
                    if (!ls) m_enter(1);
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_retry = 0;
                            m_enter(3);
                        end
                    end
                end
                3: begin
                    if (!ls) begin
                        sl = 1;
                        m_enter(0);
                    end
                end
                default: begin
                    if (clear_status) begin
                        m_retry = 0;
                        m_enter(0);
                    end
                end
            endcase
        end
        m_lost = sl | (m_lost & !clear_status);
        m_fail = sf | (m_fail & !clear_status);
    endfunction

    function automatic logic [8:0] m_out();
        logic [3:0] r;
        r = 4'(m_retry);
        return {(m_ph == 0) || (m_ph == 4), m_ph == 3, m_ph == 3,
                m_lost, m_fail, r};
    endfunction

    task automatic cmp_model(input string tag);
        chk(tag, {pll_rst, sys_resetN, lock_ok, lock_lost, fail, retry_cnt},
            m_out());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!resetN) m_reset();
        else m_step();
        cmp_model("cycle");
    endtask

    task automatic pulse_width(output int w);
        w = 0;
        while (pll_rst === 1'b1 && w < 200) begin
            tick();
            w++;
        end
    endtask

    task automatic wait_sys(input logic lvl, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sys_resetN !== lvl && n < 200);
    endtask

    task automatic rst_pulse();
        resetN = 1'b0;
        #1;
        m_reset();
        cmp_model("async_rst");
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        int n;
        int w;
        int hold;
        m_reset();

        // 1: power-up sequence
        repeat (3) tick();
        chk("rst_outs", {pll_rst, sys_resetN, lock_ok, lock_lost, fail, retry_cnt},
            9'b1_0000_0000);
        resetN = 1'b1;
        pulse_width(w);
        chk("t1_pll_rst_width", w, P_RST);
        repeat (6) tick();
        locked = 1'b1;
        wait_sys(1'b1, n);
        chk("t1_lock_to_run", n, 2 + 1 + P_STB);
        chk("t1_retry", retry_cnt, 0);

        // 4: lock loss in RUN
        locked = 1'b0;
        wait_sys(1'b0, n);
        chk("t4_drop_latency", n, 2 + 1);
        chk("t4_lost", lock_lost, 1);
        pulse_width(w);
        chk("t4_pll_rst_width", w, P_RST);
        locked = 1'b1;
        wait_sys(1'b1, n);
        chk("t4_relock", n, 2 + 1 + P_STB);
        chk("t4_lost_sticky", lock_lost, 1);

        // 5a: force in RUN
        force_reset = 1'b1;
        tick();
        force_reset = 1'b0;
        chk("t5a_pll_rst", pll_rst, 1);
        pulse_width(w);
        chk("t5a_width", w, P_RST);
        chk("t5a_lost_kept", lock_lost, 1);
        chk("t5a_retry_kept", retry_cnt, 0);

        // 2: one-cycle glitch during STABILIZE
        repeat (3) tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        wait_sys(1'b1, n);
        chk("t2_glitch_restart", n, 2 + 1 + P_STB);
        chk("t2_retry", retry_cnt, 0);

        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("clear_lost", lock_lost, 0);

        // 5b: force in WAIT_LOCK at cnt 20
        locked = 1'b0;
        force_reset = 1'b1;
        tick();
        force_reset = 1'b0;
        chk("t5b_no_lost", lock_lost, 0);
        pulse_width(w);
        chk("t5b_width1", w, P_RST);
        repeat (20) tick();
        force_reset = 1'b1;
        tick();
        force_reset = 1'b0;
        chk("t5b_pll_rst", pll_rst, 1);
        chk("t5b_retry", retry_cnt, 0);
        pulse_width(w);
        chk("t5b_width2", w, P_RST);

        // 3: timeouts, FAIL, clear
        n = 0;
        do begin
            tick();
            n++;
        end while (pll_rst !== 1'b1 && n < 200);
        chk("t3_timeout1", n, P_TO);
        chk("t3_retry1", retry_cnt, 1);
        pulse_width(w);
        chk("t3_width", w, P_RST);
        n = 0;
        do begin
            tick();
            n++;
        end while (fail !== 1'b1 && n < 200);
        chk("t3_timeout2", n, P_TO);
        chk("t3_retry2", retry_cnt, P_MAX);
        repeat (10) tick();
        chk("t3_fail_hold", {pll_rst, fail}, 2'b11);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("t3_clear", {fail, retry_cnt}, 5'b0_0000);
        pulse_width(w);
        chk("t3_clear_width", w, P_RST);

        // 6: async reset mid-STABILIZE
        locked = 1'b1;
        repeat (6) tick();
        resetN = 1'b0;
        #1;
        m_reset();
        chk("t6_async", {pll_rst, sys_resetN, lock_ok, lock_lost, fail, retry_cnt},
            9'b1_0000_0000);
        tick();
        resetN = 1'b1;
        pulse_width(w);
        chk("t6_width", w, P_RST);
        wait_sys(1'b1, n);
        chk("t6_restart", n, 1 + P_STB);

        // random traffic
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                locked = ~locked;
                hold = locked ? $urandom_range(1, 60) : $urandom_range(1, 90);
            end
            hold--;
            force_reset = ($urandom_range(0, 199) == 0);
            clear_status = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 999) == 0) begin
                force_reset = 1'b0;
                rst_pulse();
            end else begin
                tick();
            end
        end
        force_reset = 1'b0;
        clear_status = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
